// File: rtl/fc_credit_update_gen.sv
// Receive-side flow-control credit return: tracks CREDITS_ALLOCATED from freed buffer
// entries and requests InitFC1/InitFC2/UpdateFC DLLPs over a valid/ready handshake.
module fc_credit_update_gen #(
    parameter int CREDIT_WIDTH  = 8,
    parameter int INIT_CREDITS  = 16,
    parameter int UPDATE_THRESH = 4,
    parameter int TIMER_CYCLES  = 1024,
    parameter int INITFC_REPEAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    link_up,
    input  logic                    peer_fc1_seen,
    input  logic                    peer_fc2_seen,
    input  logic                    buf_rd,
    output logic                    dllp_valid,
    input  logic                    dllp_ready,
    output logic [1:0]              dllp_type,
    output logic [CREDIT_WIDTH-1:0] dllp_credits,
    output logic [CREDIT_WIDTH-1:0] credits_alloc,
    output logic                    fc_init_done,
    output logic                    err_overflow
);

    localparam int PEND_W = $clog2(INIT_CREDITS + 1);
    localparam int TMR_W  = $clog2(TIMER_CYCLES + 1);
    localparam int SENT_W = $clog2(INITFC_REPEAT + 1);

    localparam logic [CREDIT_WIDTH-1:0] INIT_ADV = CREDIT_WIDTH'(INIT_CREDITS);
    localparam logic [PEND_W-1:0]       PEND_MAX = PEND_W'(INIT_CREDITS);
    localparam logic [PEND_W-1:0]       PEND_THR = PEND_W'(UPDATE_THRESH);
    localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(TIMER_CYCLES - 1);
    localparam logic [SENT_W-1:0]       SENT_MAX = SENT_W'(INITFC_REPEAT);

    localparam logic [1:0] TYPE_INITFC1 = 2'b00;
    localparam logic [1:0] TYPE_INITFC2 = 2'b01;
    localparam logic [1:0] TYPE_UPDFC   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT1,
        S_INIT2,
        S_ACTIVE,
        S_SEND_UPD
    } state_t;

    state_t state_q, state_d;

    logic [CREDIT_WIDTH-1:0] alloc_q;
    logic [CREDIT_WIDTH-1:0] snap_q;
    logic [PEND_W-1:0]       pending_q;
    logic [PEND_W-1:0]       pending_inc;
    logic [TMR_W-1:0]        timer_q;
    logic [SENT_W-1:0]       sent_q;
    logic [SENT_W-1:0]       sent_inc;
    logic                    err_q;
    logic                    xfer;
    logic                    upd_entry;

    assign xfer        = dllp_valid && dllp_ready;
    assign sent_inc    = (sent_q < SENT_MAX) ? sent_q + 1'b1 : sent_q;
    assign pending_inc = (pending_q < PEND_MAX) ? pending_q + 1'b1 : pending_q;
    assign upd_entry   = (state_q == S_ACTIVE) && (state_d == S_SEND_UPD);

    assign dllp_credits  = snap_q;
    assign credits_alloc = alloc_q;
    assign err_overflow  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dllp_valid   = 1'b0;
        dllp_type    = TYPE_INITFC1;
        fc_init_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (link_up) state_d = S_INIT1;
            end
            S_INIT1: begin
                dllp_valid = 1'b1;
                dllp_type  = TYPE_INITFC1;
                if (xfer && (sent_inc >= SENT_MAX) && peer_fc1_seen) state_d = S_INIT2;
            end
            S_INIT2: begin
                dllp_valid = 1'b1;
                dllp_type  = TYPE_INITFC2;
                if (xfer && (sent_inc >= SENT_MAX) && peer_fc2_seen) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                fc_init_done = 1'b1;
                // Threshold and keep-alive share one transition, so coincident triggers yield one UpdateFC.
                if ((pending_q >= PEND_THR) || (timer_q == TMR_LAST)) state_d = S_SEND_UPD;
            end
            S_SEND_UPD: begin
                dllp_valid   = 1'b1;
                dllp_type    = TYPE_UPDFC;
                fc_init_done = 1'b1;
                if (xfer) state_d = S_ACTIVE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!link_up) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_q   <= '0;
            snap_q    <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            sent_q    <= '0;
            err_q     <= 1'b0;
        end else if (!link_up) begin
            alloc_q   <= '0;
            snap_q    <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            sent_q    <= '0;
            err_q     <= 1'b0;
        end else if (state_q == S_IDLE) begin
            alloc_q   <= INIT_ADV;
            snap_q    <= INIT_ADV;
            pending_q <= '0;
            timer_q   <= '0;
            sent_q    <= '0;
        end else begin
            if (buf_rd) alloc_q <= alloc_q + 1'b1;
            if (buf_rd && (pending_q == PEND_MAX)) err_q <= 1'b1;

            // Snapshot excludes a same-cycle free; that free restarts the pending count.
            if (upd_entry) begin
                snap_q    <= alloc_q;
                pending_q <= PEND_W'(buf_rd);
            end else if (buf_rd) begin
                pending_q <= pending_inc;
            end

            if ((state_q == S_ACTIVE) && (state_d == S_ACTIVE)) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end

            if (((state_q == S_INIT1) || (state_q == S_INIT2)) && (state_d == state_q)) begin
                if (xfer) sent_q <= sent_inc;
            end else begin
                sent_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fc_credit_update_gen.sv
// Scoreboard bench for fc_credit_update_gen: stimulus queues expected DLLPs, a negedge
// monitor pops and compares them on every accepted request.
module tb_fc_credit_update_gen;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_up;
    logic          peer_fc1_seen;
    logic          peer_fc2_seen;
    logic          buf_rd;
    logic          dllp_valid;
    logic          dllp_ready;
    logic [1:0]    dllp_type;
    logic [CW-1:0] dllp_credits;
    logic [CW-1:0] credits_alloc;
    logic          fc_init_done;
    logic          err_overflow;

    int errors = 0;
    int checks = 0;
    int xfer_idx = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_item;

    always #5 clk = ~clk;

    fc_credit_update_gen #(
        .CREDIT_WIDTH (CW),
        .INIT_CREDITS (16),
        .UPDATE_THRESH(4),
        .TIMER_CYCLES (1024),
        .INITFC_REPEAT(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link_up      (link_up),
        .peer_fc1_seen(peer_fc1_seen),
        .peer_fc2_seen(peer_fc2_seen),
        .buf_rd       (buf_rd),
        .dllp_valid   (dllp_valid),
        .dllp_ready   (dllp_ready),
        .dllp_type    (dllp_type),
        .dllp_credits (dllp_credits),
        .credits_alloc(credits_alloc),
        .fc_init_done (fc_init_done),
        .err_overflow (err_overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd(input int n);
        buf_rd = 1'b1;
        repeat (n) tick();
        buf_rd = 1'b0;
    endtask

    // Queue one expected DLLP and hold ready until the DUT presents a request.
    task automatic expect_xfer(input logic [1:0] t, input int c, input int budget);
        bit done;
        done = 1'b0;
        exp_q.push_back({t, 8'(c)});
        dllp_ready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            if (dllp_valid) done = 1'b1;
            tick();
        end
        dllp_ready = 1'b0;
        check("xfer_within_budget", int'(done), 1);
        if (!done) void'(exp_q.pop_back());
    endtask

    task automatic fast_init();
        int n;
        for (int i = 0; i < 2; i++) exp_q.push_back({2'b00, 8'd16});
        for (int i = 0; i < 2; i++) exp_q.push_back({2'b01, 8'd16});
        peer_fc1_seen = 1'b1;
        peer_fc2_seen = 1'b1;
        dllp_ready    = 1'b1;
        link_up       = 1'b1;
        n = 0;
        while (!fc_init_done && n < 20) begin
            tick();
            n++;
        end
        dllp_ready = 1'b0;
        check("init_done", int'(fc_init_done), 1);
        check("init_alloc", int'(credits_alloc), 16);
        check("init_sb_drained", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(dllp_valid), 0);
        check({tag, "_type"}, int'(dllp_type), 0);
        check({tag, "_credits"}, int'(dllp_credits), 0);
        check({tag, "_alloc"}, int'(credits_alloc), 0);
        check({tag, "_init_done"}, int'(fc_init_done), 0);
        check({tag, "_err"}, int'(err_overflow), 0);
    endtask

    always @(negedge clk) begin
        if (dllp_valid && dllp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected[%0d]: got type=%0d credits=%0d, expected no request",
                         xfer_idx, dllp_type, dllp_credits);
            end else begin
                exp_item = exp_q.pop_front();
                if ({dllp_type, dllp_credits} != exp_item) begin
                    errors++;
                    $display("FAIL sb_xfer[%0d]: got type=%0d credits=%0d, expected type=%0d credits=%0d",
                             xfer_idx, dllp_type, dllp_credits, exp_item[9:8], exp_item[7:0]);
                end
            end
            xfer_idx++;
        end
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        link_up       = 1'b0;
        peer_fc1_seen = 1'b0;
        peer_fc2_seen = 1'b0;
        buf_rd        = 1'b0;
        dllp_ready    = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fast init: 2x InitFC1, 2x InitFC2, all advertising 16.
        fast_init();

        // Threshold UpdateFC, then back-pressure with frees while the snapshot holds.
        pulse_rd(4);
        check("alloc_after_4", int'(credits_alloc), 20);
        tick();
        check("upd_valid", int'(dllp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            buf_rd = (i == 0 || i == 2);
            tick();
            check("hold_credits", int'(dllp_credits), 20);
            check("hold_type", int'(dllp_type), 2);
        end
        buf_rd = 1'b0;
        check("alloc_during_hold", int'(credits_alloc), 22);
        expect_xfer(2'b10, 20, 4);
        pulse_rd(2);
        check("alloc_24", int'(credits_alloc), 24);
        expect_xfer(2'b10, 24, 8);

        // Link drop clears everything.
        link_up = 1'b0;
        tick();
        check("linkdn_valid", int'(dllp_valid), 0);
        check("linkdn_alloc", int'(credits_alloc), 0);
        check("linkdn_init_done", int'(fc_init_done), 0);

        // Slow init: InitFC1 repeats until the peer's InitFC1 is seen.
        peer_fc1_seen = 1'b0;
        link_up = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) expect_xfer(2'b00, 16, 2);
        check("stay_init1_valid", int'(dllp_valid), 1);
        check("stay_init1_type", int'(dllp_type), 0);
        peer_fc1_seen = 1'b1;
        expect_xfer(2'b00, 16, 2);
        check("enter_init2_type", int'(dllp_type), 1);
        expect_xfer(2'b01, 16, 2);
        expect_xfer(2'b01, 16, 2);
        check("slow_init_done", int'(fc_init_done), 1);

        // 250 frees from 16: UpdateFC values wrap through 0, final allocation 266 mod 256.
        for (int k = 1; k <= 62; k++) begin
            pulse_rd(4);
            expect_xfer(2'b10, (16 + 4 * k) % 256, 6);
        end
        pulse_rd(2);
        check("wrap_alloc", int'(credits_alloc), 10);

        // Keep-alive with no frees.
        expect_xfer(2'b10, 10, 1200);
        n = 0;
        while (!dllp_valid && n < 1100) begin
            tick();
            n++;
        end
        check("timer_period", n, 1024);
        expect_xfer(2'b10, 10, 2);
        check("timer_alloc", int'(credits_alloc), 10);

        // Overflow: 17 frees while an UpdateFC is stalled.
        pulse_rd(4);
        check("ovf_pre_alloc", int'(credits_alloc), 14);
        tick();
        check("ovf_upd_valid", int'(dllp_valid), 1);
        buf_rd = 1'b1;
        repeat (16) tick();
        check("ovf_at_16", int'(err_overflow), 0);
        tick();
        buf_rd = 1'b0;
        check("ovf_at_17", int'(err_overflow), 1);
        check("ovf_alloc", int'(credits_alloc), 31);
        expect_xfer(2'b10, 14, 2);
        tick();
        check("ovf_next_credits", int'(dllp_credits), 31);
        check("ovf_sticky", int'(err_overflow), 1);
        link_up = 1'b0;
        tick();
        check("ovf_clear_err", int'(err_overflow), 0);
        check("ovf_clear_valid", int'(dllp_valid), 0);
        check("ovf_clear_alloc", int'(credits_alloc), 0);

        // Asynchronous reset while an UpdateFC is stalled.
        fast_init();
        pulse_rd(4);
        tick();
        check("rst_pre_valid", int'(dllp_valid), 1);
        check("rst_pre_credits", int'(dllp_credits), 20);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        link_up = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", int'(dllp_valid), 0);
        check("post_rst_init_done", int'(fc_init_done), 0);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_credit_update_gen.md
Name: fc_credit_update_gen

Overview:
Receive-side flow-control credit return stage, directly downstream of the per-type receive credit buffer. Counts entries freed by buffer reads and maintains CREDITS_ALLOCATED (modulo 2^CREDIT_WIDTH). Drives InitFC1/InitFC2 DLLP requests during link init, then UpdateFC requests toward the DLL transmit arbiter over a valid/ready handshake.

Parameters:
CREDIT_WIDTH, 8, width of advertised credit field; all credit arithmetic is modulo 2^CREDIT_WIDTH.
INIT_CREDITS, 16, credits advertised at init; equals the receive buffer depth.
UPDATE_THRESH, 4, freed-credit count that triggers an UpdateFC.
TIMER_CYCLES, 1024, maximum cycles between UpdateFCs in ACTIVE.
INITFC_REPEAT, 2, minimum accepted InitFC DLLPs per init phase.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
link_up  in  1  DL_Up level; low forces IDLE
peer_fc1_seen  in  1  level: peer InitFC1 received
peer_fc2_seen  in  1  level: peer InitFC2 or UpdateFC received
buf_rd  in  1  one-cycle pulse per entry freed (buffer rd_en && !empty)
dllp_valid  out  1  DLLP request valid
dllp_ready  in  1  arbiter accepts request
dllp_type  out  2  00 InitFC1, 01 InitFC2, 10 UpdateFC
dllp_credits  out  CREDIT_WIDTH  credit value carried by the request
credits_alloc  out  CREDIT_WIDTH  live CREDITS_ALLOCATED
fc_init_done  out  1  high in ACTIVE/SEND_UPD
err_overflow  out  1  sticky: freed credits exceed INIT_CREDITS

Behaviour:
- Reset, async: state IDLE; all outputs 0; pending, timer and sent counters 0.
- Handshake: transfer occurs when dllp_valid && dllp_ready in the same cycle. While valid && !ready, dllp_type and dllp_credits hold stable. Valid drops only after a transfer or on link_up low.
- IDLE: on link_up=1, load credits_alloc <= INIT_CREDITS mod 2^W and pending <= 0, then go to INIT1. buf_rd is ignored in IDLE.
- INIT1: dllp_valid=1, type 00, credits = INIT_CREDITS. Count transfers, saturating at INITFC_REPEAT. Go to INIT2 on a transfer cycle once count (including that transfer) >= INITFC_REPEAT and peer_fc1_seen=1; otherwise keep requesting. Sent count clears on transition.
- INIT2: same rules with type 01 and peer_fc2_seen. Exit to ACTIVE, where fc_init_done=1.
- The advertised value during INIT is always INIT_CREDITS. buf_rd in INIT states still increments credits_alloc and pending.
- ACTIVE: dllp_valid=0; timer increments each cycle. Go to SEND_UPD when pending >= UPDATE_THRESH or timer == TIMER_CYCLES-1. The timer path fires even with pending=0 as a keep-alive.
- On entry to SEND_UPD:
  - snapshot dllp_credits <= credits_alloc, the registered value excluding a same-cycle buf_rd;
  - pending <= buf_rd;
  - timer <= 0.
- SEND_UPD: dllp_valid=1, type 10, snapshot held. buf_rd still increments credits_alloc and pending. On transfer return to ACTIVE with timer = 0.
- buf_rd arithmetic: credits_alloc <= credits_alloc + 1, wrapping 2^W-1 -> 0. pending saturates at INIT_CREDITS.
- err_overflow: set when buf_rd arrives while pending == INIT_CREDITS. It is cleared only by reset or link_up low.
- link_up low in any state: next cycle goes to IDLE. dllp_valid, fc_init_done, credits_alloc, pending, timer and err_overflow go to 0. A pending request is abandoned and needs no handshake.
- Threshold and timer firing in the same cycle produce a single UpdateFC.

Test Plan:
- Reset mid-SEND_UPD with dllp_ready=0 -> all outputs 0 immediately; IDLE after release.
- link_up=1, peer_fc1/2_seen=1, ready=1 -> 2x InitFC1 (credits 16), 2x InitFC2 (16), then fc_init_done=1.
- Init with peer_fc1_seen=0 for 10 cycles, ready=1 -> InitFC1 sent continuously; INIT2 entered only after peer_fc1_seen rises.
- ACTIVE, 4 buf_rd pulses -> credits_alloc=20, UpdateFC with credits 20. Hold ready=0 for 5 cycles with 2 more buf_rd -> dllp_credits stays 20, credits_alloc=22, pending=2 after transfer.
- Drive 250 freed credits from init value 16 -> credits_alloc wraps to 10 (266 mod 256); UpdateFC values wrap correctly.
- No buf_rd in ACTIVE -> UpdateFC every TIMER_CYCLES (1024) cycles with an unchanged value.
- 17 buf_rd with ready=0 after SEND_UPD entry -> err_overflow=1, sticky until link_up low.
